// File: rtl/ascii_dec_to_bcd_if.sv
// Bundles the character stream and the converter handshake for ascii_dec_to_bcd.
// Latency: none, wires only.
// Backpressure: rx_ready from the slave stalls the character stream.
interface ascii_dec_to_bcd_if #(
  parameter int BCD_DIGITS = 4
);
  localparam int CNT_W = $clog2(BCD_DIGITS + 1);

  logic [7:0]                  rx_data;
  logic                        rx_valid;
  logic                        rx_ready;
  logic                        conv_rdy;
  logic                        conv_done;
  logic                        start;
  logic [BCD_DIGITS-1:0][3:0]  bcd_out;
  logic [CNT_W-1:0]            digit_cnt;
  logic                        err_overflow;
  logic                        err_char;

  // Environment side: character source plus BCD converter.
  modport master (
    output rx_data, rx_valid, conv_rdy, conv_done,
    input  rx_ready, start, bcd_out, digit_cnt, err_overflow, err_char
  );

  // Assembler side.
  modport slave (
    input  rx_data, rx_valid, conv_rdy, conv_done,
    output rx_ready, start, bcd_out, digit_cnt, err_overflow, err_char
  );
endinterface

// File: rtl/ascii_dec_to_bcd.sv
// Assembles ASCII decimal digits into packed BCD and launches the BCD converter on CR/LF.
// Latency: start pulses 2 cycles after the terminator when conv_rdy is already high.
// Backpressure: rx_ready drops from terminator acceptance until conv_done is consumed.
// Optional BACKSPACE_EN: 0x08/0x7F delete the last digit instead of flagging err_char.
module ascii_dec_to_bcd #(
  parameter int BCD_DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  ascii_dec_to_bcd_if.slave bus
);
  localparam int CNT_W = $clog2(BCD_DIGITS + 1);

  typedef enum logic [1:0] {
    COLLECT   = 2'd0,
    WAIT_RDY  = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [BCD_DIGITS-1:0][3:0] bcd_q, bcd_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       ovf_q, ovf_d;
  logic                       start_q, start_d;
  logic                       err_ovf_q, err_ovf_d;
  logic                       err_chr_q, err_chr_d;

  logic accept;
  logic is_digit;
  logic is_term;
`ifdef BACKSPACE_EN
  logic is_bs;
`endif

  // Character classification; rx_ready depends on state only so upstream sees no comb path from rx_valid.
  assign bus.rx_ready = (state_q == COLLECT);
  assign accept       = bus.rx_valid && (state_q == COLLECT);
  assign is_digit     = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
  assign is_term      = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
`ifdef BACKSPACE_EN
  assign is_bs        = (bus.rx_data == 8'h08) || (bus.rx_data == 8'h7F);
`endif

  // Next-state and next-output logic; pulse outputs default low so each lasts one cycle.
  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    start_d   = 1'b0;
    err_ovf_d = 1'b0;
    err_chr_d = 1'b0;

    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          if (is_digit) begin
            if (cnt_q < CNT_W'(BCD_DIGITS)) begin
              bcd_d = {bcd_q[BCD_DIGITS-2:0], bus.rx_data[3:0]};
              cnt_d = cnt_q + CNT_W'(1);
            end else begin
              // Excess digit dropped; the number is rejected at its terminator.
              ovf_d = 1'b1;
            end
          end else if (is_term) begin
            if (ovf_q) begin
              err_ovf_d = 1'b1;
              bcd_d     = '0;
              cnt_d     = '0;
              ovf_d     = 1'b0;
            end else if (cnt_q != '0) begin
              state_d = WAIT_RDY;
            end
            // Empty line (or second half of CR-LF) falls through silently.
`ifdef BACKSPACE_EN
          end else if (is_bs) begin
            if (ovf_q) begin
              // Undo only the overflow; the dropped digits are gone.
              ovf_d = 1'b0;
            end else if (cnt_q != '0) begin
              bcd_d = {4'h0, bcd_q[BCD_DIGITS-1:1]};
              cnt_d = cnt_q - CNT_W'(1);
            end
`endif
          end else begin
            err_chr_d = 1'b1;
            bcd_d     = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
          end
        end
      end

      WAIT_RDY: begin
        // conv_done is deliberately ignored here; only the launched conversion may end the wait.
        if (bus.conv_rdy) begin
          start_d = 1'b1;
          state_d = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        // bcd_out stays frozen so the converter can sample it whenever start is high.
        if (bus.conv_done) begin
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = COLLECT;
        end
      end

      default: begin
        state_d = COLLECT;
        bcd_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      start_q   <= 1'b0;
      err_ovf_q <= 1'b0;
      err_chr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      start_q   <= start_d;
      err_ovf_q <= err_ovf_d;
      err_chr_q <= err_chr_d;
    end
  end

  assign bus.start        = start_q;
  assign bus.bcd_out      = bcd_q;
  assign bus.digit_cnt    = cnt_q;
  assign bus.err_overflow = err_ovf_q;
  assign bus.err_char     = err_chr_q;
endmodule

// File: tb/tb_ascii_dec_to_bcd.sv
// Scoreboard bench for ascii_dec_to_bcd: expected start/error events are queued as stimulus is issued.
// Latency: start is expected 2 cycles after an accepted terminator when conv_rdy is high.
// Backpressure: characters are held until rx_ready is seen high.
module tb_ascii_dec_to_bcd;
  localparam int EV_START = 1;
  localparam int EV_OVF   = 2;
  localparam int EV_CHR   = 3;

  typedef struct {
    int          kind;
    logic [15:0] bcd;
    int          cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t exp_q[$];
  exp_t mon_e;
  int   mon_kind;

  ascii_dec_to_bcd_if #(.BCD_DIGITS(4)) bus();

  ascii_dec_to_bcd #(.BCD_DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int kind, input logic [15:0] bcd, input int cnt);
    exp_t e;
    e.kind = kind;
    e.bcd  = bcd;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  // Offer one character and hold it until the DUT takes it.
  task automatic send_char(input logic [7:0] c);
    int n;
    n = 0;
    bus.rx_data  = c;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    while (!bus.rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL send_timeout: char %0h not accepted after %0d cycles", c, n);
    end
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  // Play the converter: wait for start, then answer with a one-cycle conv_done.
  task automatic conv_cycle();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.start && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL start_timeout: no start within %0d cycles", n);
    end
    @(posedge clk);
    #1 bus.conv_done = 1'b1;
    @(posedge clk);
    #1 bus.conv_done = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd1);
    chk({tag, "_bcd_out"}, 32'(bus.bcd_out), 32'd0);
    chk({tag, "_digit_cnt"}, 32'(bus.digit_cnt), 32'd0);
    chk({tag, "_start"}, 32'(bus.start), 32'd0);
    chk({tag, "_err_ovf"}, 32'(bus.err_overflow), 32'd0);
    chk({tag, "_err_char"}, 32'(bus.err_char), 32'd0);
  endtask

  // Monitor: every output event must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst && (bus.start || bus.err_overflow || bus.err_char)) begin
      mon_kind = bus.start ? EV_START : (bus.err_overflow ? EV_OVF : EV_CHR);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: kind %0d bcd %0h, nothing expected", mon_kind, bus.bcd_out);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.kind != mon_kind) begin
          bad++;
          $display("FAIL event_kind: got %0d want %0d", mon_kind, mon_e.kind);
        end else if (mon_kind == EV_START &&
                     (bus.bcd_out !== mon_e.bcd || int'(bus.digit_cnt) != mon_e.cnt)) begin
          bad++;
          $display("FAIL start_word: got bcd %0h cnt %0d want bcd %0h cnt %0d",
                   bus.bcd_out, bus.digit_cnt, mon_e.bcd, mon_e.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.rx_data   = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.conv_rdy  = 1'b1;
    bus.conv_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;

    // "1234\r": full-width number, start latency and clear on done.
    push_exp(EV_START, 16'h1234, 4);
    send_str("1234");
    chk("t1_bcd", 32'(bus.bcd_out), 32'h1234);
    chk("t1_cnt", 32'(bus.digit_cnt), 32'd4);
    send_char(8'h0D);
    chk("t1_rx_ready_low", 32'(bus.rx_ready), 32'd0);
    chk("t1_start_not_yet", 32'(bus.start), 32'd0);
    @(posedge clk);
    #1;
    chk("t1_start_latency", 32'(bus.start), 32'd1);
    bus.conv_done = 1'b1;
    @(posedge clk);
    #1 bus.conv_done = 1'b0;
    chk("t1_start_one_cycle", 32'(bus.start), 32'd0);
    chk("t1_bcd_cleared", 32'(bus.bcd_out), 32'd0);
    chk("t1_cnt_cleared", 32'(bus.digit_cnt), 32'd0);
    chk("t1_rx_ready_back", 32'(bus.rx_ready), 32'd1);

    // "42\r\n": the LF after the conversion is silently dropped.
    push_exp(EV_START, 16'h0042, 2);
    send_str("42");
    send_char(8'h0D);
    conv_cycle();
    send_char(8'h0A);
    repeat (2) @(posedge clk);
    #1;
    chk("t2_cnt_after_lf", 32'(bus.digit_cnt), 32'd0);

    // "12345\r": fifth digit overflows, terminator reports and discards.
    push_exp(EV_OVF, 16'h0000, 0);
    send_str("12345");
    chk("t3_bcd_kept", 32'(bus.bcd_out), 32'h1234);
    chk("t3_cnt_kept", 32'(bus.digit_cnt), 32'd4);
    send_char(8'h0D);
    chk("t3_bcd_cleared", 32'(bus.bcd_out), 32'd0);
    chk("t3_cnt_cleared", 32'(bus.digit_cnt), 32'd0);
    chk("t3_stay_collect", 32'(bus.rx_ready), 32'd1);

    // "9a1\r": illegal char wipes the '9', then a single-digit number.
    push_exp(EV_CHR, 16'h0000, 0);
    push_exp(EV_START, 16'h0001, 1);
    send_str("9a1");
    send_char(8'h0D);
    conv_cycle();

    // "77\r" with converter busy: stream stalls, early conv_done ignored.
    bus.conv_rdy = 1'b0;
    push_exp(EV_START, 16'h0077, 2);
    send_str("77");
    send_char(8'h0D);
    bus.conv_done = 1'b1;
    @(posedge clk);
    #1 bus.conv_done = 1'b0;
    bus.rx_data  = "5";
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_rx_ready_low", 32'(bus.rx_ready), 32'd0);
      chk("t5_start_low", 32'(bus.start), 32'd0);
    end
    chk("t5_bcd_held", 32'(bus.bcd_out), 32'h0077);
    chk("t5_cnt_held", 32'(bus.digit_cnt), 32'd2);
    bus.rx_valid = 1'b0;
    bus.conv_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_start_after_rdy", 32'(bus.start), 32'd1);
    bus.conv_done = 1'b1;
    @(posedge clk);
    #1 bus.conv_done = 1'b0;
    chk("t5_bcd_cleared", 32'(bus.bcd_out), 32'd0);

`ifdef BACKSPACE_EN
    // Backspace removes the last digit.
    push_exp(EV_START, 16'h0129, 3);
    send_str("123");
    send_char(8'h08);
    chk("t6_bs_bcd", 32'(bus.bcd_out), 32'h0012);
    chk("t6_bs_cnt", 32'(bus.digit_cnt), 32'd2);
    send_str("9");
    send_char(8'h0D);
    conv_cycle();

    // DEL after overflow only clears the flag; four digits survive.
    push_exp(EV_START, 16'h1234, 4);
    send_str("12345");
    send_char(8'h7F);
    chk("t6_undo_bcd", 32'(bus.bcd_out), 32'h1234);
    send_char(8'h0D);
    conv_cycle();

    // Backspace on an empty number is a no-op.
    push_exp(EV_START, 16'h0006, 1);
    send_char(8'h08);
    chk("t6_bs_empty_cnt", 32'(bus.digit_cnt), 32'd0);
    send_str("6");
    send_char(8'h0D);
    conv_cycle();
`else
    // Without backspace support, 0x08 and 0x7F are illegal.
    push_exp(EV_CHR, 16'h0000, 0);
    push_exp(EV_CHR, 16'h0000, 0);
    send_str("3");
    send_char(8'h08);
    chk("t6_bs_illegal_cnt", 32'(bus.digit_cnt), 32'd0);
    send_str("4");
    send_char(8'h7F);
    chk("t6_del_illegal_bcd", 32'(bus.bcd_out), 32'd0);
`endif

    // Reset while waiting for conv_done.
    push_exp(EV_START, 16'h0005, 1);
    send_str("5");
    send_char(8'h0D);
    @(posedge clk);
    #1;
    chk("t7_start", 32'(bus.start), 32'd1);
    @(posedge clk);
    #1;
    chk("t7_in_wait_done", 32'(bus.rx_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_vals("t7_rst");
    rst = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
